rms_window_module: RTL and testbench
====================================

# rms_window_module

Computes the RMS magnitude of the sampled line current over a fixed window of N samples and presents it as the 16-bit `I_rms` word consumed by the overcurrent relay stage. It sits between the ADC sample interface and the relay, running on the same 800 Hz clock: one sample per clock at most, 16 samples per 50 Hz cycle. Each completed window's mean square feeds a bit-serial integer square root. The result is held stable on `I_rms` until the next window completes.

## Interface
- `LOG2N`, default 4: log2 of window length N (N = 16 = one 50 Hz cycle); legal range 4..6.
- `clk_800hz`  input  1  800 Hz clock; all logic on rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `sample_in`  input  16  signed two's-complement current sample, same scale as `I_rms`.
- `sample_valid`  input  1  `sample_in` accepted on any edge where high.
- `I_rms`  output  16  unsigned floor(sqrt(mean of squares)) of last completed window; held between updates.
- `rms_valid`  output  1  one-cycle pulse when `I_rms` takes a new value.
- `busy`  output  1  square-root engine iterating.

## Operation
- Squaring: `sq = sample_in * sample_in`, signed 16x16, result treated as unsigned 32-bit; max 2^30 (at -32768).
- Accumulator: unsigned, 16+16+LOG2N-1 bits minimum (35 bits for N=16); never overflows. Adds `sq` on each accepted sample.
- Sample counter: LOG2N bits, counts accepted samples only; gaps in `sample_valid` neither advance nor disturb the window.
- Window completion: the edge accepting the N-th sample:
  - Radicand <= (acc + sq) >> LOG2N, truncated to 32 bits (≤ 2^30, so lossless).
  - Accumulator and counter clear to 0. The completing sample belongs to the finished window, not the next.
  - Square-root engine starts.
- Square root: non-restoring/digit-by-digit integer floor sqrt of a 32-bit radicand. Exactly one result bit per cycle, MSB first, 16 iterations. Result range 0..32768; 32768 (0x8000) fits 16 bits unsigned.
- Engine states:
  - IDLE: `busy`=0. Window completion -> BUSY, iteration index 0.
  - BUSY: `busy`=1. Index increments each edge. On iteration 15, write result to `I_rms`, pulse `rms_valid`, then -> IDLE.
- Simultaneous events: if a window completes on the same edge as iteration 15, the finished result is still written and pulsed. The new radicand loads, index resets to 0, and the state stays BUSY. No result is lost, and no window is skipped.
- The engine cannot be restarted mid-computation. With LOG2N ≥ 4 and at most one sample per clock, the next completion is never earlier than the final iteration edge.
- `I_rms` changes only on the `rms_valid` edge; at all other times it holds its value.
- Reset, including mid-window or mid-sqrt:
  - Accumulator, counter, radicand, partial root and index clear to 0.
  - State -> IDLE; `I_rms`=0, `rms_valid`=0, `busy`=0.
  - The in-flight window and computation are discarded; the first window after reset starts with the first sample accepted after reset deasserts.

## Timing
- Reset values: `I_rms`=0x0000, `rms_valid`=0, `busy`=0.
- Window completes at edge T.
- `busy` is high from after edge T through edge T+16.
- `I_rms` updates and `rms_valid`=1 at edge T+16; `rms_valid` returns to 0 at T+17 unless another result is written there.
- Latency from the N-th sample edge to new `I_rms`: 16 clocks, fixed, independent of data.
- Continuous samples at N=16 give one result every 16 clocks (every 20 ms); `busy` stays high continuously after the first window.
- Before the first result after reset, `I_rms` reads 0.

## Test plan
- 16 consecutive samples of +1000 -> 16 clocks after the 16th sample, `I_rms`=1000 with a single `rms_valid` pulse; `busy` high exactly 16 cycles.
- Alternating +3000/-3000, continuous over 3 windows -> `I_rms`=3000 at clocks 32, 48, 64 (1-based, relative to the first sample); `busy` never drops after the first start; `rms_valid` pulses exactly 3 times.
- 16 samples of -32768 -> `I_rms`=0x8000; 8 samples of 0 then 8 of +2 -> mean 2 -> `I_rms`=1 (floor check).
- Samples of +500 with `sample_valid` deasserted for random gaps -> result only after 16 accepted samples, `I_rms`=500; gap cycles do not count.
- Reset asserted after 10 samples, and separately at iteration 8 of the sqrt -> `I_rms`=0, `busy`=0, no `rms_valid`. The next 16 samples of +700 give `I_rms`=700.
- Window completion coincident with iteration 15 (back-to-back windows of +100 then +200) -> 100 then 200 output 16 clocks apart, both pulsed.

Source files
------------

// File: rtl/rms_window_module.sv
`default_nettype none
// ============================================================================
//  Module   : rms_window_module
//  Purpose  : Windowed RMS of signed current samples: mean of squares over
//             2**LOG2N samples followed by a 16-step bit-serial integer sqrt.
//  Revision : 1.0 - initial release
// ============================================================================
module rms_window_module #(
    parameter int LOG2N = 4
) (
    input  logic        clk_800hz,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] I_rms,
    output logic        rms_valid,
    output logic        busy
);

    localparam int               c_acc_w     = 32 + LOG2N;
    localparam logic [LOG2N-1:0] c_cnt_last  = '1;
    localparam logic [3:0]       c_last_iter = 4'd15;
    localparam logic [0:0]       c_st_idle   = 1'b0;
    localparam logic [0:0]       c_st_busy   = 1'b1;

    logic [c_acc_w-1:0] r_acc;
    logic [LOG2N-1:0]   r_cnt;
    logic [31:0]        r_rad;
    logic [15:0]        r_rem;
    logic [15:0]        r_root;
    logic [3:0]         r_idx;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nx;

    logic signed [31:0] w_sq_s;
    logic [31:0]        w_sq;
    logic [c_acc_w-1:0] w_sum;
    logic [c_acc_w-1:0] w_mean;
    logic               w_win_done;
    logic               w_last_iter;
    logic [17:0]        w_rem_sh;
    logic [17:0]        w_trial;
    logic               w_ge;
    logic [17:0]        w_rem_nx;
    logic [15:0]        w_root_nx;
    logic               w_unused_bits;

    assign w_sq_s     = $signed(sample_in) * $signed(sample_in);
    assign w_sq       = w_sq_s;
    assign w_sum      = r_acc + {{LOG2N{1'b0}}, w_sq};
    assign w_mean     = w_sum >> LOG2N;
    assign w_win_done = sample_valid && (r_cnt == c_cnt_last);

    // One root bit per cycle: bring down the next radicand digit pair and
    // try subtracting (4*root + 1).
    assign w_rem_sh    = {r_rem, r_rad[31:30]};
    assign w_trial     = {r_root, 2'b01};
    assign w_ge        = (w_rem_sh >= w_trial);
    assign w_rem_nx    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nx   = {r_root[14:0], w_ge};
    assign w_last_iter = (r_state == c_st_busy) && (r_idx == c_last_iter);

    // Mean is at most 2**30 and the remainder fits 16 bits before the last step.
    assign w_unused_bits = ^{w_mean[c_acc_w-1:32], w_rem_nx[17:16]};

    assign busy = (r_state == c_st_busy);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle: if (w_win_done) w_state_nx = c_st_busy;
            c_st_busy: if (w_last_iter && !w_win_done) w_state_nx = c_st_idle;
            default:   w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_800hz) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk_800hz) begin
        if (reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_idx     <= '0;
            I_rms     <= '0;
            rms_valid <= 1'b0;
        end else begin
            rms_valid <= 1'b0;

            if (sample_valid) begin
                if (w_win_done) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (r_state == c_st_busy) begin
                r_rem  <= w_rem_nx[15:0];
                r_root <= w_root_nx;
                r_rad  <= {r_rad[29:0], 2'b00};
                r_idx  <= r_idx + 4'd1;
            end

            if (w_last_iter) begin
                I_rms     <= w_root_nx;
                rms_valid <= 1'b1;
            end

            // A completing window overrides the engine registers, so a
            // completion on the final iteration edge chains straight on.
            if (w_win_done) begin
                r_rad  <= w_mean[31:0];
                r_rem  <= '0;
                r_root <= '0;
                r_idx  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rms_window_module.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rms_window_module
//  Purpose  : Scoreboard bench for rms_window_module with directed windows.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rms_window_module;

    logic        clk_800hz = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] I_rms;
    logic        rms_valid;
    logic        busy;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_cmp     = 0;
    int   n_fail    = 0;
    int   busy_cnt  = 0;
    int   pulse_cnt = 0;
    int   p0;

    always #5 clk_800hz = ~clk_800hz;
    always @(posedge clk_800hz) cyc <= cyc + 1;

    rms_window_module #(.LOG2N(4)) dut (
        .clk_800hz    (clk_800hz),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .I_rms        (I_rms),
        .rms_valid    (rms_valid),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk_800hz) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (rms_valid) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                check("unexpected rms_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("I_rms value", int'(I_rms), int'(e.val));
                check("I_rms cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic [15:0] v, input logic vld);
        sample_in    = v;
        sample_valid = vld;
        @(posedge clk_800hz);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'h7fff, 1'b0);
    endtask

    // halves: first 8 samples a, last 8 b; otherwise a/b alternate.
    task automatic send_window(input logic [15:0] a, input logic [15:0] b,
                               input bit halves, input bit gaps,
                               input bit push, input logic [15:0] expv);
        for (int i = 0; i < 16; i++) begin
            if (gaps) idle(i % 3);
            if (halves) drive((i < 8) ? a : b, 1'b1);
            else        drive((i % 2 == 1) ? b : a, 1'b1);
        end
        if (push) sb.push_back('{expv, cyc + 16});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'h0;
        repeat (3) @(posedge clk_800hz);
        #1;
        reset = 1'b0;
        @(negedge clk_800hz);
        check("reset I_rms", int'(I_rms), 0);
        check("reset rms_valid", int'(rms_valid), 0);
        check("reset busy", int'(busy), 0);
        #1;

        busy_cnt = 0;
        p0 = pulse_cnt;
        send_window(16'd1000, 16'd1000, 1'b0, 1'b0, 1'b1, 16'd1000);
        idle(20);
        check("busy cycles single", busy_cnt, 16);
        check("pulses single", pulse_cnt - p0, 1);

        busy_cnt = 0;
        p0 = pulse_cnt;
        for (int w = 0; w < 3; w++)
            send_window(16'd3000, 16'hF448, 1'b0, 1'b0, 1'b1, 16'd3000);
        idle(20);
        check("busy cycles continuous", busy_cnt, 48);
        check("pulses continuous", pulse_cnt - p0, 3);

        send_window(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000);
        idle(20);
        send_window(16'd0, 16'd2, 1'b1, 1'b0, 1'b1, 16'd1);
        idle(20);

        send_window(16'd500, 16'd500, 1'b0, 1'b1, 1'b1, 16'd500);
        idle(20);

        for (int i = 0; i < 10; i++) drive(16'd1000, 1'b1);
        reset = 1'b1;
        drive(16'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk_800hz);
        check("mid-window reset I_rms", int'(I_rms), 0);
        check("mid-window reset busy", int'(busy), 0);
        #1;
        send_window(16'd700, 16'd700, 1'b0, 1'b0, 1'b1, 16'd700);
        idle(20);

        p0 = pulse_cnt;
        send_window(16'd1000, 16'd1000, 1'b0, 1'b0, 1'b0, 16'd0);
        idle(8);
        reset = 1'b1;
        drive(16'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk_800hz);
        check("mid-sqrt reset I_rms", int'(I_rms), 0);
        check("mid-sqrt reset busy", int'(busy), 0);
        #1;
        idle(20);
        check("pulses after mid-sqrt reset", pulse_cnt - p0, 0);
        send_window(16'd700, 16'd700, 1'b0, 1'b0, 1'b1, 16'd700);
        idle(20);

        send_window(16'd100, 16'd100, 1'b0, 1'b0, 1'b1, 16'd100);
        send_window(16'd200, 16'd200, 1'b0, 1'b0, 1'b1, 16'd200);
        idle(40);

        check("pending results", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
